// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
// The frame is laid out so bit 0 leaves the shift register first.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      BIT
   } state_t;

   localparam int          DATA_W     = 8;
   localparam int          FRAME_W    = 10;
   localparam logic [3:0]  LAST_BIT   = 4'd9;
   localparam logic        START_BIT  = 1'b0;
   localparam logic        STOP_BIT   = 1'b1;
   localparam logic [FRAME_W-1:0] IDLE_FRAME = 10'h3FF;

   // Start bit sits in the LSB so it goes out first on a right shift.
   function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] data);
      return {STOP_BIT, data, START_BIT};
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; tick marks the last clock of each bit.
// Shared with the receiver, so it carries no knowledge of frames.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] baud_cnt;

   assign tick = enable && (baud_cnt == TERM);

   always_ff @(posedge clk) begin
      if (reset || clear)
         baud_cnt <= '0;
      else if (enable)
         baud_cnt <= tick ? '0 : baud_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/uart_tx_controller.sv
// Transmit sequencer: one-byte holding buffer feeding load/shift strobes
// for an external 10-bit right-shifting TX register.
module uart_tx_controller
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               tx_sr_load,
   output logic               tx_sr_shift,
   output logic [FRAME_W-1:0] tx_sr_in,
   output logic               tx_busy,
   output logic               tx_done
);

   state_t             state, state_nxt;
   logic [3:0]         bit_cnt;
   logic [DATA_W-1:0]  buf_data;
   logic               buf_full;
   logic               tick;
   logic               frame_end;
   logic               consume;

   uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != BIT),
      .enable (state == BIT),
      .tick   (tick)
   );

   assign frame_end = (state == BIT) && tick && (bit_cnt == LAST_BIT);
   assign consume   = buf_full && ((state == IDLE) || frame_end);
   assign tx_ready  = !buf_full;

   // Accept needs an empty buffer and consume needs a full one, so the
   // two branches below are mutually exclusive in practice.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full <= 1'b0;
         buf_data <= '0;
      end else if (consume) begin
         buf_full <= 1'b0;
      end else if (tx_valid && !buf_full) begin
         buf_full <= 1'b1;
         buf_data <= tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         bit_cnt <= '0;
      else if (state != BIT)
         bit_cnt <= '0;
      else if (tick)
         bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    state_nxt = IDLE;
         IDLE:    if (buf_full) state_nxt = BIT;
         BIT:     if (frame_end && !buf_full) state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   always_comb begin
      tx_sr_load  = 1'b0;
      tx_sr_shift = 1'b0;
      tx_sr_in    = IDLE_FRAME;
      tx_busy     = 1'b0;
      tx_done     = 1'b0;
      case (state)
         INIT: tx_sr_load = 1'b1;
         IDLE: begin
            if (buf_full) begin
               tx_sr_load = 1'b1;
               tx_sr_in   = make_frame(buf_data);
               tx_busy    = 1'b1;
            end
         end
         BIT: begin
            tx_busy = 1'b1;
            if (frame_end) begin
               tx_done    = 1'b1;
               tx_sr_load = 1'b1;
               if (buf_full)
                  tx_sr_in = make_frame(buf_data);
            end else if (tick) begin
               tx_sr_shift = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
